adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Sequences one shared WIDTH-bit adder core between two requesters.
- Each requester presents a mode bit and two operands, then gets a registered result and a one-cycle done pulse.
- Sits between two datapath clients (e.g. PC-increment path and ALU path) and the adder.
- Provides round-robin arbitration, operand capture, mode-correct arithmetic and result holding.

Parameters:
- WIDTH, 8, operand width. Bit WIDTH-1 is the sign in sign-magnitude mode.
- FAIR, 1, 1 = round-robin arbitration, 0 = fixed priority (requester 0 always wins).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- iReq0  in  1  requester 0 request, level.
- iSA0  in  1  requester 0 mode: 1 = sign-magnitude, 0 = unsigned.
- iData_a0  in  WIDTH  requester 0 operand a.
- iData_b0  in  WIDTH  requester 0 operand b.
- iReq1, iSA1, iData_a1, iData_b1  in  1/1/WIDTH/WIDTH  requester 1, same meaning as requester 0.
- oDone0  out  1  one-cycle pulse: result for requester 0 valid.
- oDone1  out  1  one-cycle pulse: result for requester 1 valid.
- oData  out  WIDTH+1  result, held until the next result or reset.
- oData_C  out  1  carry/overflow flag for oData, held with oData.
- oGrant  out  2  one-hot owner of the adder; 00 when idle.
- oBusy  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset: synchronous, active-high, one clock, overrides all else. State goes to IDLE. oDone0/1, oData, oData_C, oGrant and oBusy go to 0. Last-served pointer goes to 1, so requester 0 wins the first tie.
- Reset mid-operation aborts the operation: no done pulse, result cleared.
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
- IDLE: requests are sampled only in this state.
  - No request: stay in IDLE.
  - At least one request: at the clock edge, pick the winner, latch the winner's iSA/iData_a/iData_b into internal registers, set oGrant, go to EXEC.
- Arbitration:
  - Only one request high: it wins.
  - Both high with FAIR=1: the requester other than last-served wins.
  - Both high with FAIR=0: requester 0 wins.
  - Last-served pointer updates at grant.
- EXEC: the adder core computes from latched operands only; input changes are ignored. At the edge, oData and oData_C are registered and state goes to DONE.
- DONE: oDone of the granted requester is 1 for exactly this cycle. At the edge, go to IDLE and clear oGrant.
- Latency: request sampled at edge N -> oDone high between edges N+1 and N+2. Throughput is one operation per 3 cycles.
- Handshake: a requester drops iReq on or after seeing oDone. An iReq still high in IDLE is a new request. A losing requester keeps iReq high and is served next.
- Arithmetic, mode 0 (unsigned):
  - {C,S} = a + b, zero-extended to WIDTH+1 bits.
  - oData = sum, oData_C = sum[WIDTH].
- Arithmetic, mode 1 (sign-magnitude):
  - Each operand = (-1)^sign × magnitude of bits WIDTH-2:0.
  - Convert each to WIDTH+1-bit two's complement and add.
  - oData = two's-complement sum.
  - oData_C = 1 if |sum| > 2^(WIDTH-1)-1 (not representable in WIDTH-bit sign-magnitude), else 0.
  - Negative zero (sign=1, magnitude=0) equals 0.
  - The sum is always exact in WIDTH+1 bits.
- Simultaneous events: a new request arriving during EXEC/DONE waits for IDLE. Requests dropped before IDLE are never served.

Decomposition:
- Package adder_arb_pkg holds:
  - state encoding: IDLE=2'd0, EXEC=2'd1, DONE=2'd2
  - mode constants MODE_UNS=1'b0, MODE_SM=1'b1
  - grant encodings GNT_NONE/GNT0/GNT1
- One combinational sub-module, add_core:
  - inputs: mode, a, b
  - outputs: WIDTH+1 sum, flag
  - contains the arithmetic rules above and is instantiated once.
- FSM, arbiter and registers stay in adder_arbiter.

Test Plan:
- Unsigned: req0, iSA0=0, a=8'd200, b=8'd100 -> oDone0 pulses 2 cycles after sampling; oData=9'h12C, oData_C=1, oGrant=01 during EXEC/DONE.
- Sign-magnitude: req1, iSA1=1, a=8'h85 (-5), b=8'h03 -> oData=9'h1FE (-2), oData_C=0, only oDone1 pulses.
- Overflow and negative zero (iSA=1):
  - a=8'h7F, b=8'h01 -> oData=9'h080, oData_C=1.
  - a=8'h80, b=8'h80 -> oData=0, oData_C=0.
- Tie, FAIR=1: first tie after reset, both req held -> req0 served, then req1, then req0. Each oDone is a single cycle, 3 cycles apart. With FAIR=0, req0 is served every time.
- Operand stability: change iData_a0 during EXEC -> result uses the value latched at grant.
- Reset: assert rst during EXEC -> next cycle all outputs 0, no oDone. The held request is re-served from scratch after rst falls.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared encodings for the two-requester adder arbiter: FSM states,
// arithmetic modes and one-hot grant values.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_UNS = 1'b0;
    localparam logic MODE_SM  = 1'b1;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT0     = 2'b01;
    localparam logic [1:0] GNT1     = 2'b10;

endpackage

// File: rtl/adder_arbiter_add_core.sv
// Combinational adder core: unsigned add with carry, or sign-magnitude add
// producing a WIDTH+1-bit two's-complement sum and a representability flag.
module add_core
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum,
    output logic             o_flag
);

    localparam logic [WIDTH:0] SM_MAX = (WIDTH+1)'((2 ** (WIDTH-1)) - 1);

    logic [WIDTH:0] w_uns_sum;
    logic [WIDTH:0] w_mag_a;
    logic [WIDTH:0] w_mag_b;
    logic [WIDTH:0] w_tc_a;
    logic [WIDTH:0] w_tc_b;
    logic [WIDTH:0] w_sm_sum;
    logic [WIDTH:0] w_sm_abs;

    assign w_uns_sum = {1'b0, i_a} + {1'b0, i_b};

    // Negating a zero magnitude yields zero, so negative zero needs no special case.
    assign w_mag_a = {2'b00, i_a[WIDTH-2:0]};
    assign w_mag_b = {2'b00, i_b[WIDTH-2:0]};
    assign w_tc_a  = i_a[WIDTH-1] ? (~w_mag_a + 1'b1) : w_mag_a;
    assign w_tc_b  = i_b[WIDTH-1] ? (~w_mag_b + 1'b1) : w_mag_b;

    assign w_sm_sum = w_tc_a + w_tc_b;
    assign w_sm_abs = w_sm_sum[WIDTH] ? (~w_sm_sum + 1'b1) : w_sm_sum;

    assign o_sum  = (i_mode == MODE_SM) ? w_sm_sum : w_uns_sum;
    assign o_flag = (i_mode == MODE_SM) ? (w_sm_abs > SM_MAX) : w_uns_sum[WIDTH];

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder core between two requesters: arbitrates in IDLE, latches
// the winner's operands, registers the result and pulses the winner's done.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iReq0,
    input  logic             iSA0,
    input  logic [WIDTH-1:0] iData_a0,
    input  logic [WIDTH-1:0] iData_b0,
    input  logic             iReq1,
    input  logic             iSA1,
    input  logic [WIDTH-1:0] iData_a1,
    input  logic [WIDTH-1:0] iData_b1,
    output logic             oDone0,
    output logic             oDone1,
    output logic [WIDTH:0]   oData,
    output logic             oData_C,
    output logic [1:0]       oGrant,
    output logic             oBusy
);

    state_t           r_state;
    logic             r_last;
    logic             r_mode;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_grant;
    logic             r_done0;
    logic             r_done1;
    logic [WIDTH:0]   r_data;
    logic             r_c;
    logic             r_busy;

    logic             w_any_req;
    logic             w_pick1;
    logic [WIDTH:0]   w_sum;
    logic             w_flag;

    // Requester 1 wins alone, or on a tie when fair and requester 0 was served last.
    assign w_any_req = iReq0 | iReq1;
    assign w_pick1   = iReq1 & (~iReq0 | (FAIR & ~r_last));

    add_core #(.WIDTH(WIDTH)) u_add_core (
        .i_mode (r_mode),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_sum  (w_sum),
        .o_flag (w_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_mode  <= MODE_UNS;
            r_a     <= '0;
            r_b     <= '0;
            r_grant <= GNT_NONE;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_data  <= '0;
            r_c     <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_mode  <= w_pick1 ? iSA1     : iSA0;
                        r_a     <= w_pick1 ? iData_a1 : iData_a0;
                        r_b     <= w_pick1 ? iData_b1 : iData_b0;
                        r_grant <= w_pick1 ? GNT1     : GNT0;
                        r_last  <= w_pick1;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_data  <= w_sum;
                    r_c     <= w_flag;
                    r_done0 <= r_grant[0];
                    r_done1 <= r_grant[1];
                    r_state <= DONE;
                end
                DONE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_grant <= GNT_NONE;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_grant <= GNT_NONE;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign oDone0  = r_done0;
    assign oDone1  = r_done1;
    assign oData   = r_data;
    assign oData_C = r_c;
    assign oGrant  = r_grant;
    assign oBusy   = r_busy;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on every done pulse.
module tb_adder_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       iReq0, iSA0, iReq1, iSA1;
    logic [7:0] iData_a0, iData_b0, iData_a1, iData_b1;
    logic       oDone0, oDone1, oData_C, oBusy;
    logic [8:0] oData;
    logic [1:0] oGrant;
    logic       f_done0, f_done1, f_c, f_busy;
    logic [8:0] f_data;
    logic [1:0] f_grant;

    typedef struct {
        logic       who;
        logic [8:0] data;
        logic       c;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   fix_cnt = 0;
    bit   tie_win = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_arbiter #(.WIDTH(8), .FAIR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .iReq0(iReq0), .iSA0(iSA0), .iData_a0(iData_a0), .iData_b0(iData_b0),
        .iReq1(iReq1), .iSA1(iSA1), .iData_a1(iData_a1), .iData_b1(iData_b1),
        .oDone0(oDone0), .oDone1(oDone1), .oData(oData), .oData_C(oData_C),
        .oGrant(oGrant), .oBusy(oBusy)
    );

    adder_arbiter #(.WIDTH(8), .FAIR(1'b0)) u_fix (
        .clk(clk), .rst(rst),
        .iReq0(iReq0), .iSA0(iSA0), .iData_a0(iData_a0), .iData_b0(iData_b0),
        .iReq1(iReq1), .iSA1(iSA1), .iData_a1(iData_a1), .iData_b1(iData_b1),
        .oDone0(f_done0), .oDone1(f_done1), .oData(f_data), .oData_C(f_c),
        .oGrant(f_grant), .oBusy(f_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no done expected done within bound (cycle %0d)", name, cyc);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (oDone0 || oDone1)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=%b%b expected none", oDone1, oDone0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_who", {30'd0, oDone1, oDone0}, mon_e.who ? 32'd2 : 32'd1);
                check("data", {23'd0, oData}, {23'd0, mon_e.data});
                check("carry", {31'd0, oData_C}, {31'd0, mon_e.c});
            end
        end
        if (tie_win && !rst && (f_done0 || f_done1)) begin
            fix_cnt++;
            check("fix_who", {30'd0, f_done1, f_done0}, 32'd1);
            check("fix_data", {23'd0, f_data}, 32'h01E);
        end
    end

    task automatic set_req(input logic who, input logic req, input logic sa,
                           input logic [7:0] a, input logic [7:0] b);
        if (who) begin
            iReq1 = req; iSA1 = sa; iData_a1 = a; iData_b1 = b;
        end else begin
            iReq0 = req; iSA0 = sa; iData_a0 = a; iData_b0 = b;
        end
    endtask

    task automatic do_op(input logic who, input logic sa, input logic [7:0] a,
                         input logic [7:0] b, input logic [8:0] ed, input logic ec,
                         input logic chg, input logic [7:0] a_new);
        bit got = 1'b0;
        int lat = 0;
        sb_q.push_back('{who, ed, ec});
        @(posedge clk); #1;
        set_req(who, 1'b1, sa, a, b);
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (i == 2) begin
                check("grant_exec", {30'd0, oGrant}, who ? 32'd2 : 32'd1);
                check("busy_exec", {31'd0, oBusy}, 32'd1);
                if (chg) begin
                    if (who) iData_a1 = a_new; else iData_a0 = a_new;
                end
            end
            if (who ? oDone1 : oDone0) begin
                got = 1'b1;
                lat = i;
            end
        end
        if (!got) timeout("op_done");
        else check("latency", lat, 32'd3);
        if (who) iReq1 = 1'b0; else iReq0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  d_cyc[3];
        int  k;
        bit  got;
        int  lat;

        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        check("rst_data", {23'd0, oData}, 32'd0);
        check("rst_c", {31'd0, oData_C}, 32'd0);
        check("rst_grant", {30'd0, oGrant}, 32'd0);
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        check("rst_done", {30'd0, oDone1, oDone0}, 32'd0);
        rst = 1'b0;

        // who, sa, a, b, expected data, expected flag, change a mid-op, new a
        do_op(1'b0, 1'b0, 8'd200, 8'd100, 9'h12C, 1'b1, 1'b0, 8'h00);
        do_op(1'b1, 1'b1, 8'h85,  8'h03,  9'h1FE, 1'b0, 1'b0, 8'h00);
        do_op(1'b0, 1'b1, 8'h7F,  8'h01,  9'h080, 1'b1, 1'b0, 8'h00);
        do_op(1'b1, 1'b1, 8'h80,  8'h80,  9'h000, 1'b0, 1'b0, 8'h00);
        do_op(1'b0, 1'b1, 8'hFF,  8'hFF,  9'h102, 1'b1, 1'b0, 8'h00);
        do_op(1'b1, 1'b0, 8'hFF,  8'hFF,  9'h1FE, 1'b1, 1'b0, 8'h00);
        do_op(1'b0, 1'b0, 8'h0F,  8'h01,  9'h010, 1'b0, 1'b0, 8'h00);
        do_op(1'b0, 1'b0, 8'h10,  8'h01,  9'h011, 1'b0, 1'b1, 8'hF0);

        // Reset during EXEC aborts, then the held request is served afresh.
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b0, 8'd3, 8'd4);
        repeat (2) @(negedge clk);
        check("abort_grant_exec", {30'd0, oGrant}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_data", {23'd0, oData}, 32'd0);
        check("abort_c", {31'd0, oData_C}, 32'd0);
        check("abort_grant", {30'd0, oGrant}, 32'd0);
        check("abort_busy", {31'd0, oBusy}, 32'd0);
        check("abort_done", {30'd0, oDone1, oDone0}, 32'd0);
        rst = 1'b0;
        sb_q.push_back('{1'b1, 9'h007, 1'b0});
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (oDone1) begin
                got = 1'b1;
                lat = i;
            end
        end
        if (!got) timeout("reserve_done");
        else check("reserve_latency", lat, 32'd2);
        iReq1 = 1'b0;

        // First tie after reset: 0, 1, 0 with FAIR=1; always 0 with FAIR=0.
        do_reset();
        tie_win = 1'b1;
        sb_q.push_back('{1'b0, 9'h01E, 1'b0});
        sb_q.push_back('{1'b1, 9'h1FE, 1'b0});
        sb_q.push_back('{1'b0, 9'h01E, 1'b0});
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 8'd10, 8'd20);
        set_req(1'b1, 1'b1, 1'b1, 8'h85, 8'h03);
        k = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            @(negedge clk);
            if (oDone0 || oDone1) begin
                d_cyc[k] = cyc;
                k++;
            end
        end
        iReq0 = 1'b0;
        iReq1 = 1'b0;
        if (k < 3) begin
            timeout("tie_dones");
        end else begin
            check("tie_gap1", d_cyc[1] - d_cyc[0], 32'd3);
            check("tie_gap2", d_cyc[2] - d_cyc[1], 32'd3);
        end
        repeat (4) @(negedge clk);
        tie_win = 1'b0;
        check("fix_count", fix_cnt, 32'd3);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
